// File: rtl/transient_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : transient_scheduler
// Description : Watches four 2-bit channels for changes and times a
//               per-channel transient window. A single shared down-counter
//               serves all channels. Pending requests are granted
//               round-robin, or by fixed priority when TS_FIXED_PRIO_EN
//               is defined.
// Options     : TS_FIXED_PRIO_EN - fixed priority, with channel 0 highest
// Revision    : 1.0 - initial release
// ============================================================================
module transient_scheduler #(
    parameter int TICK_SCALE = 10000,
    parameter int CNT_W      = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] chan_in,
    input  logic [3:0] delay_sel,
    output logic [3:0] hold_o,
    output logic       busy,
    output logic [1:0] grant,
    output logic [3:0] pend
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_TICK = CNT_W'(TICK_SCALE);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t             state_q;
    logic [7:0]         chan_q;
    logic [3:0]         pend_q, pend_d;
    logic [3:0]         chg;
    logic [3:0]         clr_mask;
    logic [3:0]         hold_q;
    logic               busy_q;
    logic [1:0]         grant_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   load_val;
    logic [1:0]         sel;
    logic               take;

    // Per-channel change detect, comparing the live input with last cycle's copy.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chg
            assign chg[gi] = (chan_in[2*gi +: 2] != chan_q[2*gi +: 2]);
        end
    endgenerate

    // Register the channel inputs; cleared on reset so a non-zero input counts as a change.
    always_ff @(posedge clk) begin
        if (reset) chan_q <= 8'h00;
        else       chan_q <= chan_in;
    end

`ifdef TS_FIXED_PRIO_EN
    // Fixed priority: the lowest-numbered pending channel wins.
    always_comb begin
        sel = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (pend_q[k]) sel = 2'(k);
        end
    end
`else
    logic [1:0] last_grant_q;
    logic [1:0] idx;
    logic       found;

    // Round-robin: search upward from the channel after the last one served.
    always_comb begin
        sel   = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant_q + 2'(k);
            if (!found && pend_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
`endif

    // A grant is taken whenever the timer is free and something is waiting.
    assign take     = (state_q == S_IDLE) && (|pend_q);
    assign clr_mask = take ? (4'b0001 << sel) : 4'b0000;
    // A new change takes precedence over the grant clear in the same cycle.
    assign pend_d   = (pend_q & ~clr_mask) | chg;
    assign load_val = CNT_W'(delay_sel) * C_TICK;

    // Pending request flags.
    always_ff @(posedge clk) begin
        if (reset) pend_q <= 4'b0000;
        else       pend_q <= pend_d;
    end

    // Window FSM with registered grant/hold/busy outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            grant_q      <= 2'd0;
            hold_q       <= 4'b0000;
            busy_q       <= 1'b0;
`ifndef TS_FIXED_PRIO_EN
            last_grant_q <= 2'd3;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (take) begin
                        grant_q <= sel;
                        hold_q  <= 4'b0001 << sel;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // delay_sel is sampled here only; later changes wait for the next window.
                    cnt_q   <= load_val;
                    state_q <= S_COUNT;
                end
                S_COUNT: begin
                    if (cnt_q == '0) begin
                        hold_q       <= 4'b0000;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
`ifndef TS_FIXED_PRIO_EN
                        last_grant_q <= grant_q;
`endif
                    end else begin
                        cnt_q <= cnt_q - C_ONE;
                    end
                end
                default: begin
                    hold_q  <= 4'b0000;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign hold_o = hold_q;
    assign busy   = busy_q;
    assign grant  = grant_q;
    assign pend   = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_transient_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_transient_scheduler
// Description : Self-checking bench for transient_scheduler with TICK_SCALE=4.
//               A window-level reference model predicts hold/busy/grant/pend
//               every cycle. Directed scenarios are combined with random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_transient_scheduler;

    localparam int TS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] chan_in;
    logic [3:0] delay_sel;
    logic [3:0] hold_o;
    logic       busy;
    logic [1:0] grant;
    logic [3:0] pend;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    transient_scheduler #(.TICK_SCALE(TS), .CNT_W(18)) dut (
        .clk       (clk),
        .reset     (reset),
        .chan_in   (chan_in),
        .delay_sel (delay_sel),
        .hold_o    (hold_o),
        .busy      (busy),
        .grant     (grant),
        .pend      (pend)
    );

    // Reference model: window position and length, not a counter.
    bit [3:0] m_pend;
    bit [7:0] m_prev;
    bit       m_busy;
    int       m_age, m_len, m_owner, m_last;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit [3:0] chg;
        bit [3:0] clr;
        int c;
        if (reset) begin
            m_pend = 0; m_prev = 0; m_busy = 0;
            m_age = 0; m_len = 0; m_owner = 0; m_last = 3;
        end else begin
            chg = 0;
            clr = 0;
            for (int i = 0; i < 4; i++)
                chg[i] = (chan_in[2*i +: 2] != m_prev[2*i +: 2]);
            if (m_busy) begin
                if (m_age == 0) begin
                    m_len = 2 + int'(delay_sel) * TS;
                    m_age = 1;
                end else if (m_age == m_len - 1) begin
                    m_busy = 0;
                    m_last = m_owner;
                end else begin
                    m_age++;
                end
            end else if (m_pend != 0) begin
                c = -1;
`ifdef TS_FIXED_PRIO_EN
                for (int k = 0; k < 4; k++)
                    if (c < 0 && m_pend[k]) c = k;
`else
                for (int k = 1; k <= 4; k++)
                    if (c < 0 && m_pend[(m_last + k) % 4]) c = (m_last + k) % 4;
`endif
                m_owner = c;
                m_busy  = 1;
                m_age   = 0;
                clr[c]  = 1'b1;
            end
            m_pend = (m_pend & ~clr) | chg;
            m_prev = chan_in;
        end
    endtask

    // One clock: update the model from the pre-edge inputs, then compare outputs after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("hold", int'(hold_o), m_busy ? (1 << m_owner) : 0);
        check_val("busy", int'(busy), int'(m_busy));
        check_val("pend", int'(pend), int'(m_pend));
        if (m_busy) check_val("grant", int'(grant), m_owner);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int hc, ng, g3, g0, prev_g, alt_err;
        int seq[4];
        bit pb;

        reset     = 1'b1;
        chan_in   = 8'h00;
        delay_sel = 4'd0;
        do_reset();
        check_val("rst_hold", int'(hold_o), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_pend", int'(pend), 0);
        check_val("rst_grant", int'(grant), 0);

        // Scenario 1: a single change with delay_sel=2 gives a 10-cycle window.
        delay_sel = 4'd2;
        chan_in   = 8'h01;
        step();
        check_val("s1_pend", int'(pend), 1);
        check_val("s1_hold_early", int'(hold_o), 0);
        step();
        check_val("s1_hold_load", int'(hold_o), 1);
        hc = 1;
        for (int i = 0; i < 40 && hold_o == 4'b0001; i++) begin
            step();
            if (hold_o == 4'b0001) hc++;
        end
        check_val("s1_hold_len", hc, 10);
        check_val("s1_busy_end", int'(busy), 0);

        // Scenario 2: all four channels change at once; grants drain 0,1,2,3.
        do_reset();
        delay_sel = 4'd0;
        chan_in   = 8'h55;
        ng = 0;
        pb = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy && !pb && ng < 4) begin
                seq[ng] = int'(grant);
                ng++;
            end
            pb = busy;
        end
        check_val("s2_ngrants", ng, 4);
        for (int i = 0; i < 4; i++) check_val("s2_seq", seq[i], i);
        check_val("s2_pend_drained", int'(pend), 0);

        // Scenario 3: channel 1 re-changes mid-window and is served again afterwards.
        do_reset();
        delay_sel = 4'd3;
        chan_in   = 8'h04;
        for (int i = 0; i < 5; i++) step();
        chan_in = 8'h08;
        step();
        check_val("s3_repend", int'(pend[1]), 1);
        for (int i = 0; i < 40; i++) step();

        // Scenario 4: delay_sel changes during COUNT and only affects the next window.
        do_reset();
        delay_sel = 4'd1;
        chan_in   = 8'h40;
        for (int i = 0; i < 4; i++) step();
        delay_sel = 4'd15;
        chan_in   = 8'h80;
        for (int i = 0; i < 80; i++) step();

        // Scenario 5: reset during COUNT aborts the window and drops pending requests.
        delay_sel = 4'd3;
        chan_in   = 8'h33;
        for (int i = 0; i < 6; i++) step();
        reset = 1'b1;
        step();
        check_val("s5_hold", int'(hold_o), 0);
        check_val("s5_busy", int'(busy), 0);
        check_val("s5_pend", int'(pend), 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Scenario 6: channels 0 and 3 toggle continuously.
        do_reset();
        delay_sel = 4'd0;
        g3 = 0; g0 = 0; prev_g = -1; alt_err = 0; pb = 1'b0;
        for (int i = 0; i < 200; i++) begin
            chan_in = chan_in ^ 8'hC3;
            step();
            if (busy && !pb) begin
                if (grant == 2'd3) g3++;
                if (grant == 2'd0) g0++;
                if (prev_g == int'(grant)) alt_err++;
                prev_g = int'(grant);
            end
            pb = busy;
        end
        check_val("s6_g0", int'(g0 > 0), 1);
`ifdef TS_FIXED_PRIO_EN
        check_val("s6_g3_never", g3, 0);
`else
        check_val("s6_g3_seen", int'(g3 > 0), 1);
        check_val("s6_alternate", alt_err, 0);
`endif

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) chan_in = 8'($urandom);
            delay_sel = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            reset     = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/transient_scheduler.md
TRANSIENT_SCHEDULER -- requirements
Module: transient_scheduler

Interface
REQ-001 SHALL have parameter TICK_SCALE, default 10000, giving clock cycles per delay unit.
REQ-002 SHALL have parameter CNT_W, default 18, giving the window counter width; 15*TICK_SCALE SHALL fit in CNT_W bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port chan_in, input, 8 bits: four 2-bit monitored channels; channel i is chan_in[2i+1:2i].
REQ-006 SHALL have port delay_sel, input, 4 bits: window length in TICK_SCALE units.
REQ-007 SHALL have port hold_o, output, 4 bits: per-channel transient-window flag.
REQ-008 SHALL have port busy, output, 1 bit: high while a window is being timed.
REQ-009 SHALL have port grant, output, 2 bits: index of the channel owning the shared timer; valid only while busy.
REQ-010 SHALL have port pend, output, 4 bits: per-channel pending-request flags.

Function
REQ-011 SHALL register chan_in into chan_q every cycle; chg[i] SHALL be high when channel i of chan_in differs from channel i of chan_q.
REQ-012 SHALL set pend[i] on the cycle after chg[i] is high; pend[i] SHALL clear only when channel i is granted.
REQ-013 SHALL keep pend[i] set if chg[i] is high on the same cycle as its grant clear (set wins).
REQ-014 SHALL set pend[g] again on a change on the granted channel g during its own window; the running window SHALL NOT restart.
REQ-015 SHALL implement FSM states IDLE, LOAD and COUNT.
REQ-016 IDLE: with any pend bit set, SHALL select a channel, drive it on grant, clear its pend bit and go to LOAD; otherwise SHALL stay in IDLE.
REQ-017 Selection SHALL be round-robin, searching from last_grant+1 upward with wrap 3->0; last_grant SHALL reset to 3, so channel 0 wins first.
REQ-018 LOAD: SHALL load counter with delay_sel*TICK_SCALE, computed at CNT_W bits with no truncation, and go to COUNT; delay_sel SHALL be sampled only here.
REQ-019 COUNT: SHALL decrement counter each cycle; with counter==0, SHALL go to IDLE and update last_grant to grant.
REQ-020 Window length SHALL be 1 LOAD cycle plus delay_sel*TICK_SCALE+1 COUNT cycles; delay_sel=0 SHALL give a 2-cycle window.
REQ-021 hold_o[grant] SHALL be high in LOAD and COUNT; all other hold_o bits SHALL be low; hold_o SHALL be all-zero in IDLE.
REQ-022 busy SHALL be high exactly when the state is not IDLE.
REQ-023 SHALL return through IDLE for at least one cycle between consecutive windows.
REQ-024 Latency from a chan_in change to hold_o high SHALL be 3 cycles when the FSM is idle: chg, then pend, then LOAD.

Reset
REQ-025 On reset, state SHALL be IDLE and SHALL apply: counter=0, chan_q=0, pend=0, last_grant=3, grant=0, hold_o=0, busy=0.
REQ-026 Reset asserted mid-window SHALL abort the window on the next edge and discard all pending requests.
REQ-027 After reset, any non-zero channel in chan_in SHALL register as a change on the first cycle, because chan_q=0.

Configuration
REQ-028 Macro TS_FIXED_PRIO_EN: when defined, selection SHALL be fixed priority with channel 0 highest, and last_grant SHALL be unused.
REQ-029 Without TS_FIXED_PRIO_EN, selection SHALL be round-robin per REQ-017.

Verification (TICK_SCALE=4)
REQ-030 Scenario 1: reset, then chan_in 0x00->0x01 with delay_sel=2 -> pend=0001 next cycle; hold_o=0001 3 cycles after the change; hold_o high for 1+9 cycles; then busy=0.
REQ-031 Scenario 2: all four channels change in one cycle, delay_sel=0 -> grant sequence 0,1,2,3, each window 2 cycles with 1 IDLE cycle between; pend drains 1111->0000.
REQ-032 Scenario 3: channel 1 changes again mid-window -> window not extended; pend[1] re-set; second window on channel 1 after the current one ends.
REQ-033 Scenario 4: delay_sel changes from 1 to 15 during COUNT -> current window keeps 1*4+1 COUNT cycles; next window uses 15*4.
REQ-034 Scenario 5: reset pulsed during COUNT -> next cycle hold_o=0, busy=0, pend=0.
REQ-035 Scenario 6: with TS_FIXED_PRIO_EN, channels 0 and 3 held toggling continuously -> channel 3 never granted; without the macro -> grants alternate 0,3.
